gpsreceiver3_capture: RTL and testbench
=======================================

GPSRECEIVER3_CAPTURE -- requirements
Module: gpsreceiver3_capture

Interface
REQ-001 SHALL have parameter CHANNELS, default 1, number of GPS front-end channels captured.
REQ-002 SHALL have parameter SAMPLE_BITS, default 2, bits per channel sample (sign, magnitude); CHANNELS*SAMPLE_BITS SHALL be one of 1, 2, 4, 8.
REQ-003 SHALL have parameter BANK_AW, default 9, word-address width of one buffer bank (2^BANK_AW 32-bit words per bank).
REQ-004 SHALL have port sys_clk  in  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port gps_rec_clk  in  1  front-end sample clock, asynchronous, sampled as data.
REQ-007 SHALL have port gps_rec_sync  in  1  front-end frame sync, asynchronous.
REQ-008 SHALL have port gps_rec_data  in  CHANNELS*SAMPLE_BITS  sample bits, asynchronous; channel c occupies bits [c*SAMPLE_BITS +: SAMPLE_BITS].
REQ-009 SHALL have port enable  in  1  capture enable level from control interface.
REQ-010 SHALL have port sync_align  in  1  when 1, capture starts on first sample with sync high.
REQ-011 SHALL have port bank_ack  in  2  one-cycle pulses; bit b clears bank_full[b].
REQ-012 SHALL have port mem_adr  out  BANK_AW+1  RAM write address {bank, word index}.
REQ-013 SHALL have port mem_dat  out  32  packed word.
REQ-014 SHALL have port mem_we  out  1  one-cycle write strobe.
REQ-015 SHALL have port bank_full  out  2  per-bank full flags.
REQ-016 SHALL have port overflow_count  out  16  dropped-sample counter, saturating.
REQ-017 SHALL have port irq  out  1  one-cycle pulse on bank completion.

Function
REQ-018 SHALL pass gps_rec_clk, gps_rec_sync, gps_rec_data through equal-depth two-flop synchronisers; sample strobe = rising edge of synchronised clock (1 then 0 in previous cycle); data/sync taken from the same synchronised stage.
REQ-019 SHALL be correct for gps_rec_clk frequency below sys_clk/4.
REQ-020 SHALL pack P = 32/(CHANNELS*SAMPLE_BITS) samples per word; sample k of a word at bits [k*W +: W], W = CHANNELS*SAMPLE_BITS, first sample in LSBs.
REQ-021 SHALL assert mem_we for exactly one cycle, the cycle after the strobe completing a word, with mem_dat and mem_adr valid in that cycle.
REQ-022 SHALL implement FSM IDLE, WAIT_SYNC, CAPTURE, STALL.
REQ-023 IDLE -> WAIT_SYNC when enable=1 and sync_align=1; IDLE -> CAPTURE when enable=1 and sync_align=0.
REQ-024 WAIT_SYNC -> CAPTURE on a strobe with sync=1; that sample SHALL be packed as sample 0 of the first word.
REQ-025 On writing word index 2^BANK_AW-1: set bank_full[bank] and pulse irq in the mem_we cycle, toggle bank, word index -> 0.
REQ-026 If the newly selected bank is already full, SHALL enter STALL; every strobe in STALL SHALL increment overflow_count (saturate at 0xFFFF) and discard the sample.
REQ-027 STALL -> CAPTURE when the current bank's full flag clears; packing SHALL restart at sample 0 of word 0.
REQ-028 Any state -> IDLE the cycle after enable=0; partial word discarded, bank and word index reset to 0; bank_full and overflow_count retained.
REQ-029 overflow_count SHALL clear to 0 on the IDLE -> WAIT_SYNC/CAPTURE transition.
REQ-030 bank_ack[b] and a set of bank_full[b] in the same cycle: set SHALL win.
REQ-031 bank_ack on a non-full bank SHALL have no effect.
REQ-032 Strobes in IDLE SHALL be ignored and SHALL NOT count as overflow.

Reset
REQ-033 On sys_rst: FSM IDLE, synchronisers 0, bank 0, word index 0, pack count 0, mem_we 0, mem_adr 0, mem_dat 0, bank_full 0, overflow_count 0, irq 0.
REQ-034 Reset mid-capture SHALL abandon the partial word with no write.

Structure
REQ-035 Shared package SHALL hold FSM state encoding and the W/P derivation constants; the CSR block (gpsreceiver3_ctlif) drives enable, sync_align, bank_ack.
REQ-036 Synchroniser plus edge detector SHALL be one sub-module, gpsreceiver3_sync.

Verification
REQ-037 Defaults, sync_align=0, 16 strobes with data 2'b01 -> one write, mem_adr 0, mem_dat 0x55555555.
REQ-038 CHANNELS=4, SAMPLE_BITS=2, strobes with data 0x01,0x02,0x03,0x04 -> mem_dat 0x04030201.
REQ-039 BANK_AW=2, fill 8 words without ack -> bank_full=2'b11, irq twice, further 5 strobes -> overflow_count=5; bank_ack=2'b01 -> next write at mem_adr 0.
REQ-040 sync_align=1, sync high on strobe 7 -> first word holds samples 7..22 only.
REQ-041 enable dropped after 10 strobes -> no write, IDLE; re-enable -> first write at mem_adr 0, overflow_count 0.
REQ-042 bank_ack[0] coinciding with bank 0 completion -> bank_full[0]=1 afterwards.

Source files
------------

// File: rtl/gpsreceiver3_capture_pkg.sv
// Shared definitions for the GPS front-end capture block: FSM state
// encoding and the sample-width / samples-per-word derivation.
package gpsreceiver3_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_STALL     = 2'd3
    } cap_state_t;

    localparam int WORD_BITS = 32;

    // W: bits of one multi-channel sample (all channels side by side).
    function automatic int sample_width(input int channels, input int sample_bits);
        return channels * sample_bits;
    endfunction

    // P: how many multi-channel samples fit into one 32-bit RAM word.
    function automatic int samples_per_word(input int channels, input int sample_bits);
        return WORD_BITS / (channels * sample_bits);
    endfunction

endpackage

// File: rtl/gpsreceiver3_capture_if.sv
// RAM write port of the capture block.
// Write-only strobe bus: mem_we is high for exactly one cycle per word and
// mem_adr/mem_dat are valid in that cycle; there is no ready, so the RAM
// must accept a write in any cycle.
interface gpsreceiver3_capture_if #(
    parameter int BANK_AW = 9
);
    logic [BANK_AW:0] mem_adr;
    logic [31:0]      mem_dat;
    logic             mem_we;

    modport master (output mem_adr, output mem_dat, output mem_we);
    modport slave  (input  mem_adr, input  mem_dat, input  mem_we);
endinterface

// File: rtl/gpsreceiver3_sync.sv
// Two-flop synchronisers for the asynchronous front-end signals plus a
// rising-edge detector on the synchronised sample clock. Clock, sync and
// data share the same depth so data/sync line up with the strobe.
module gpsreceiver3_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rec_clk,
    input  logic         rec_sync,
    input  logic [W-1:0] rec_data,
    output logic         strobe,
    output logic         sync,
    output logic [W-1:0] data
);
    logic         clk_s1, clk_s2, clk_prev;
    logic         sync_s1, sync_s2;
    logic [W-1:0] data_s1, data_s2;

    // Synchroniser chains and the delayed clock copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b0;
            clk_s2   <= 1'b0;
            clk_prev <= 1'b0;
            sync_s1  <= 1'b0;
            sync_s2  <= 1'b0;
            data_s1  <= '0;
            data_s2  <= '0;
        end else begin
            clk_s1   <= rec_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            sync_s1  <= rec_sync;
            sync_s2  <= sync_s1;
            data_s1  <= rec_data;
            data_s2  <= data_s1;
        end
    end

    assign strobe = clk_s2 & ~clk_prev;
    assign sync   = sync_s2;
    assign data   = data_s2;
endmodule

// File: rtl/gpsreceiver3_capture.sv
// GPS front-end sample capture: packs synchronised samples into 32-bit
// words and writes them into a two-bank RAM ring, with per-bank full
// flags, completion interrupt and a saturating dropped-sample counter.
module gpsreceiver3_capture
    import gpsreceiver3_capture_pkg::*;
#(
    parameter int CHANNELS    = 1,
    parameter int SAMPLE_BITS = 2,
    parameter int BANK_AW     = 9
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    input  logic                              gps_rec_clk,
    input  logic                              gps_rec_sync,
    input  logic [CHANNELS*SAMPLE_BITS-1:0]   gps_rec_data,
    input  logic                              enable,
    input  logic                              sync_align,
    input  logic [1:0]                        bank_ack,
    gpsreceiver3_capture_if.master            mem,
    output logic [1:0]                        bank_full,
    output logic [15:0]                       overflow_count,
    output logic                              irq,
    output cap_state_t                        state
);
    localparam int W   = sample_width(CHANNELS, SAMPLE_BITS);
    localparam int P   = samples_per_word(CHANNELS, SAMPLE_BITS);
    localparam int PCW = $clog2(P);
    localparam logic [BANK_AW-1:0] LAST_WORD = '1;
    localparam logic [PCW-1:0]     LAST_SLOT = PCW'(P - 1);

    logic               strobe;
    logic               s_sync;
    logic [W-1:0]       s_data;
    logic               bank;
    logic [BANK_AW-1:0] word_idx;
    logic [PCW-1:0]     pack_cnt;
    logic [31:0]        accum;
    logic [31:0]        packed_word;
    logic [1:0]         bank_full_acked;

    gpsreceiver3_sync #(.W(W)) u_sync (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .rec_clk  (gps_rec_clk),
        .rec_sync (gps_rec_sync),
        .rec_data (gps_rec_data),
        .strobe   (strobe),
        .sync     (s_sync),
        .data     (s_data)
    );

    // Current word with the incoming sample dropped into its slot.
    always_comb begin
        packed_word = accum;
        packed_word[int'(pack_cnt) * W +: W] = s_data;
    end

    // Full flags after this cycle's acknowledges; a same-cycle set is OR-ed on top.
    always_comb begin
        bank_full_acked = bank_full & ~bank_ack;
    end

    // Capture FSM with packing, bank management and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state          <= ST_IDLE;
            bank           <= 1'b0;
            word_idx       <= '0;
            pack_cnt       <= '0;
            accum          <= '0;
            mem.mem_we     <= 1'b0;
            mem.mem_adr    <= '0;
            mem.mem_dat    <= '0;
            bank_full      <= 2'b00;
            overflow_count <= 16'd0;
            irq            <= 1'b0;
        end else begin
            mem.mem_we <= 1'b0;
            irq        <= 1'b0;
            bank_full  <= bank_full_acked;
            if (!enable) begin
                state    <= ST_IDLE;
                bank     <= 1'b0;
                word_idx <= '0;
                pack_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state          <= sync_align ? ST_WAIT_SYNC : ST_CAPTURE;
                        overflow_count <= 16'd0;
                        bank           <= 1'b0;
                        word_idx       <= '0;
                        pack_cnt       <= '0;
                    end
                    ST_WAIT_SYNC: begin
                        // pack_cnt is 0 here, so the sync sample lands in slot 0.
                        if (strobe && s_sync) begin
                            accum    <= packed_word;
                            pack_cnt <= PCW'(1);
                            state    <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (strobe) begin
                            accum <= packed_word;
                            if (pack_cnt == LAST_SLOT) begin
                                pack_cnt    <= '0;
                                mem.mem_we  <= 1'b1;
                                mem.mem_dat <= packed_word;
                                mem.mem_adr <= {bank, word_idx};
                                if (word_idx == LAST_WORD) begin
                                    bank_full <= bank_full_acked | (2'b01 << bank);
                                    irq       <= 1'b1;
                                    bank      <= ~bank;
                                    word_idx  <= '0;
                                    if (bank_full_acked[~bank]) begin
                                        state <= ST_STALL;
                                    end
                                end else begin
                                    word_idx <= word_idx + 1'b1;
                                end
                            end else begin
                                pack_cnt <= pack_cnt + 1'b1;
                            end
                        end
                    end
                    ST_STALL: begin
                        if (strobe && overflow_count != 16'hFFFF) begin
                            overflow_count <= overflow_count + 16'd1;
                        end
                        if (!bank_full_acked[bank]) begin
                            state    <= ST_CAPTURE;
                            pack_cnt <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gpsreceiver3_capture.sv
// Directed bench for gpsreceiver3_capture: a small-bank single-channel
// instance (dut_a) and a four-channel instance (dut_b) share the front-end
// clock/sync and the control inputs.
module tb_gpsreceiver3_capture;
    import gpsreceiver3_capture_pkg::*;

    logic        sys_clk;
    logic        sys_rst;
    logic        gps_clk;
    logic        gps_sync;
    logic [1:0]  gps_data_a;
    logic [7:0]  gps_data_b;
    logic        enable;
    logic        sync_align;
    logic [1:0]  bank_ack;
    logic [1:0]  bank_full_a, bank_full_b;
    logic [15:0] ovf_a, ovf_b;
    logic        irq_a, irq_b;
    cap_state_t  state_a, state_b;

    gpsreceiver3_capture_if #(.BANK_AW(2)) mem_a ();
    gpsreceiver3_capture_if #(.BANK_AW(9)) mem_b ();

    gpsreceiver3_capture #(.CHANNELS(1), .SAMPLE_BITS(2), .BANK_AW(2)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .gps_rec_clk(gps_clk),
        .gps_rec_sync(gps_sync), .gps_rec_data(gps_data_a), .enable(enable),
        .sync_align(sync_align), .bank_ack(bank_ack), .mem(mem_a),
        .bank_full(bank_full_a), .overflow_count(ovf_a), .irq(irq_a), .state(state_a)
    );

    gpsreceiver3_capture #(.CHANNELS(4), .SAMPLE_BITS(2), .BANK_AW(9)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .gps_rec_clk(gps_clk),
        .gps_rec_sync(gps_sync), .gps_rec_data(gps_data_b), .enable(enable),
        .sync_align(sync_align), .bank_ack(bank_ack), .mem(mem_b),
        .bank_full(bank_full_b), .overflow_count(ovf_b), .irq(irq_b), .state(state_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0]  wr_adr_a[$];
    logic [31:0] wr_dat_a[$];
    logic [9:0]  wr_adr_b[$];
    logic [31:0] wr_dat_b[$];
    int          irq_cnt_a = 0;
    logic [31:0] exp_q[$];

    // Clock and reset
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Write/irq monitor
    always @(negedge sys_clk) begin
        if (mem_a.mem_we) begin
            wr_adr_a.push_back(mem_a.mem_adr);
            wr_dat_a.push_back(mem_a.mem_dat);
        end
        if (mem_b.mem_we) begin
            wr_adr_b.push_back(mem_b.mem_adr);
            wr_dat_b.push_back(mem_b.mem_dat);
        end
        if (irq_a) irq_cnt_a++;
    end

    // One front-end sample; ack is held from the clock rise up to the strobe cycle.
    task automatic strobe(input logic [1:0] da, input logic [7:0] db, input logic s,
                          input logic [1:0] ack);
        @(negedge sys_clk);
        gps_clk = 1'b0; gps_data_a = da; gps_data_b = db; gps_sync = s;
        repeat (4) @(negedge sys_clk);
        gps_clk = 1'b1; bank_ack = ack;
        repeat (3) @(negedge sys_clk);
        bank_ack = 2'b00;
        @(negedge sys_clk);
        gps_clk = 1'b0;
    endtask

    task automatic set_en(input logic en, input logic sa);
        @(negedge sys_clk);
        enable = en; sync_align = sa;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic settle();
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_checks++; if (state_a !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", state_a, ST_IDLE); else n_pass++;
        n_checks++; if (mem_a.mem_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", mem_a.mem_we); else n_pass++;
        n_checks++; if (mem_a.mem_adr !== 3'd0) $display("FAIL reset_adr: got %h expected 0", mem_a.mem_adr); else n_pass++;
        n_checks++; if (mem_a.mem_dat !== 32'd0) $display("FAIL reset_dat: got %h expected 0", mem_a.mem_dat); else n_pass++;
        n_checks++; if (bank_full_a !== 2'b00) $display("FAIL reset_full: got %b expected 00", bank_full_a); else n_pass++;
        n_checks++; if (ovf_a !== 16'd0) $display("FAIL reset_ovf: got %0d expected 0", ovf_a); else n_pass++;
        n_checks++; if (irq_a !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq_a); else n_pass++;
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_basic();
        int wb, ib;
        logic [2:0]  ga;
        logic [31:0] gd;
        set_en(1'b1, 1'b0);
        wb = wr_adr_a.size(); ib = irq_cnt_a;
        for (int i = 0; i < 16; i++) strobe(2'b01, 8'h00, 1'b0, 2'b00);
        settle();
        ga = (wr_adr_a.size() > wb) ? wr_adr_a[wb] : 3'bxxx;
        gd = (wr_dat_a.size() > wb) ? wr_dat_a[wb] : 32'hxxxxxxxx;
        n_checks++; if (wr_adr_a.size() - wb !== 1) $display("FAIL basic_count: got %0d expected 1", wr_adr_a.size() - wb); else n_pass++;
        n_checks++; if (ga !== 3'd0) $display("FAIL basic_adr: got %h expected 0", ga); else n_pass++;
        n_checks++; if (gd !== 32'h55555555) $display("FAIL basic_dat: got %h expected 55555555", gd); else n_pass++;
        n_checks++; if (irq_cnt_a - ib !== 0) $display("FAIL basic_irq: got %0d expected 0", irq_cnt_a - ib); else n_pass++;
        n_checks++; if (state_a !== ST_CAPTURE) $display("FAIL basic_state: got %0d expected %0d", state_a, ST_CAPTURE); else n_pass++;
    endtask

    task automatic test_sync_align();
        int wb;
        logic [2:0]  ga;
        logic [31:0] gd;
        set_en(1'b0, 1'b0);
        set_en(1'b1, 1'b1);
        n_checks++; if (state_a !== ST_WAIT_SYNC) $display("FAIL sync_state: got %0d expected %0d", state_a, ST_WAIT_SYNC); else n_pass++;
        wb = wr_adr_a.size();
        for (int i = 0; i < 23; i++) begin
            logic [4:0] iv;
            iv = 5'(i);
            strobe(iv[1:0], 8'h00, (i == 7), 2'b00);
        end
        settle();
        ga = (wr_adr_a.size() > wb) ? wr_adr_a[wb] : 3'bxxx;
        gd = (wr_dat_a.size() > wb) ? wr_dat_a[wb] : 32'hxxxxxxxx;
        n_checks++; if (wr_adr_a.size() - wb !== 1) $display("FAIL sync_count: got %0d expected 1", wr_adr_a.size() - wb); else n_pass++;
        n_checks++; if (ga !== 3'd0) $display("FAIL sync_adr: got %h expected 0", ga); else n_pass++;
        n_checks++; if (gd !== 32'h93939393) $display("FAIL sync_dat: got %h expected 93939393", gd); else n_pass++;
    endtask

    task automatic test_fill_overflow();
        int wb, ib;
        logic [2:0]  ga;
        logic [31:0] gd;
        set_en(1'b0, 1'b0);
        set_en(1'b1, 1'b0);
        wb = wr_adr_a.size(); ib = irq_cnt_a;
        exp_q.delete();
        for (int w = 0; w < 8; w++) begin
            logic [2:0] wv;
            wv = 3'(w);
            exp_q.push_back(32'(wv[1:0]) * 32'h55555555);
            for (int i = 0; i < 16; i++) strobe(wv[1:0], 8'h00, 1'b0, 2'b00);
        end
        settle();
        n_checks++; if (wr_adr_a.size() - wb !== 8) $display("FAIL fill_count: got %0d expected 8", wr_adr_a.size() - wb); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            ga = (wr_adr_a.size() > wb + i) ? wr_adr_a[wb + i] : 3'bxxx;
            gd = (wr_dat_a.size() > wb + i) ? wr_dat_a[wb + i] : 32'hxxxxxxxx;
            n_checks++; if (ga !== 3'(i)) $display("FAIL fill_adr[%0d]: got %h expected %h", i, ga, 3'(i)); else n_pass++;
            n_checks++; if (gd !== exp_q[i]) $display("FAIL fill_dat[%0d]: got %h expected %h", i, gd, exp_q[i]); else n_pass++;
        end
        n_checks++; if (irq_cnt_a - ib !== 2) $display("FAIL fill_irq: got %0d expected 2", irq_cnt_a - ib); else n_pass++;
        n_checks++; if (bank_full_a !== 2'b11) $display("FAIL fill_full: got %b expected 11", bank_full_a); else n_pass++;
        n_checks++; if (state_a !== ST_STALL) $display("FAIL fill_state: got %0d expected %0d", state_a, ST_STALL); else n_pass++;
        for (int i = 0; i < 5; i++) strobe(2'b11, 8'h00, 1'b0, 2'b00);
        settle();
        n_checks++; if (ovf_a !== 16'd5) $display("FAIL stall_ovf: got %0d expected 5", ovf_a); else n_pass++;
        n_checks++; if (wr_adr_a.size() - wb !== 8) $display("FAIL stall_nowrite: got %0d expected 8", wr_adr_a.size() - wb); else n_pass++;
        @(negedge sys_clk); bank_ack = 2'b01;
        @(negedge sys_clk); bank_ack = 2'b00;
        repeat (2) @(negedge sys_clk);
        n_checks++; if (bank_full_a !== 2'b10) $display("FAIL ack_full: got %b expected 10", bank_full_a); else n_pass++;
        n_checks++; if (state_a !== ST_CAPTURE) $display("FAIL ack_state: got %0d expected %0d", state_a, ST_CAPTURE); else n_pass++;
        for (int i = 0; i < 16; i++) strobe(2'b10, 8'h00, 1'b0, 2'b00);
        settle();
        ga = (wr_adr_a.size() > wb + 8) ? wr_adr_a[wb + 8] : 3'bxxx;
        gd = (wr_dat_a.size() > wb + 8) ? wr_dat_a[wb + 8] : 32'hxxxxxxxx;
        n_checks++; if (ga !== 3'd0) $display("FAIL resume_adr: got %h expected 0", ga); else n_pass++;
        n_checks++; if (gd !== 32'hAAAAAAAA) $display("FAIL resume_dat: got %h expected aaaaaaaa", gd); else n_pass++;
    endtask

    task automatic test_disable_reenable();
        int wb;
        logic [2:0]  ga;
        logic [31:0] gd;
        set_en(1'b0, 1'b0);
        n_checks++; if (state_a !== ST_IDLE) $display("FAIL dis_state: got %0d expected %0d", state_a, ST_IDLE); else n_pass++;
        n_checks++; if (ovf_a !== 16'd5) $display("FAIL dis_ovf_kept: got %0d expected 5", ovf_a); else n_pass++;
        n_checks++; if (bank_full_a !== 2'b10) $display("FAIL dis_full_kept: got %b expected 10", bank_full_a); else n_pass++;
        set_en(1'b1, 1'b0);
        n_checks++; if (ovf_a !== 16'd0) $display("FAIL en_ovf_clr: got %0d expected 0", ovf_a); else n_pass++;
        wb = wr_adr_a.size();
        for (int i = 0; i < 10; i++) strobe(2'b01, 8'h00, 1'b0, 2'b00);
        set_en(1'b0, 1'b0);
        settle();
        n_checks++; if (wr_adr_a.size() - wb !== 0) $display("FAIL dis_nowrite: got %0d expected 0", wr_adr_a.size() - wb); else n_pass++;
        n_checks++; if (state_a !== ST_IDLE) $display("FAIL dis_idle: got %0d expected %0d", state_a, ST_IDLE); else n_pass++;
        set_en(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            logic [4:0] iv;
            iv = 5'(i);
            strobe(iv[1:0], 8'h00, 1'b0, 2'b00);
        end
        settle();
        ga = (wr_adr_a.size() > wb) ? wr_adr_a[wb] : 3'bxxx;
        gd = (wr_dat_a.size() > wb) ? wr_dat_a[wb] : 32'hxxxxxxxx;
        n_checks++; if (ga !== 3'd0) $display("FAIL reen_adr: got %h expected 0", ga); else n_pass++;
        n_checks++; if (gd !== 32'hE4E4E4E4) $display("FAIL reen_dat: got %h expected e4e4e4e4", gd); else n_pass++;
        n_checks++; if (ovf_a !== 16'd0) $display("FAIL reen_ovf: got %0d expected 0", ovf_a); else n_pass++;
    endtask

    task automatic test_ack_collision();
        int ib;
        set_en(1'b0, 1'b0);
        @(negedge sys_clk); bank_ack = 2'b10;
        @(negedge sys_clk); bank_ack = 2'b00;
        @(negedge sys_clk);
        n_checks++; if (bank_full_a !== 2'b00) $display("FAIL clr_full: got %b expected 00", bank_full_a); else n_pass++;
        set_en(1'b1, 1'b0);
        ib = irq_cnt_a;
        for (int i = 0; i < 64; i++) strobe(2'b00, 8'h00, 1'b0, (i == 63) ? 2'b01 : 2'b00);
        settle();
        n_checks++; if (bank_full_a !== 2'b01) $display("FAIL coll_full: got %b expected 01", bank_full_a); else n_pass++;
        n_checks++; if (irq_cnt_a - ib !== 1) $display("FAIL coll_irq: got %0d expected 1", irq_cnt_a - ib); else n_pass++;
        n_checks++; if (state_a !== ST_CAPTURE) $display("FAIL coll_state: got %0d expected %0d", state_a, ST_CAPTURE); else n_pass++;
        @(negedge sys_clk); bank_ack = 2'b10;
        @(negedge sys_clk); bank_ack = 2'b00;
        @(negedge sys_clk);
        n_checks++; if (bank_full_a !== 2'b01) $display("FAIL ack_nonfull: got %b expected 01", bank_full_a); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int wb;
        logic [2:0]  ga;
        logic [31:0] gd;
        set_en(1'b0, 1'b0);
        set_en(1'b1, 1'b0);
        wb = wr_adr_a.size();
        for (int i = 0; i < 8; i++) strobe(2'b11, 8'h00, 1'b0, 2'b00);
        @(negedge sys_clk); sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        n_checks++; if (state_a !== ST_IDLE) $display("FAIL rmid_state: got %0d expected %0d", state_a, ST_IDLE); else n_pass++;
        n_checks++; if (bank_full_a !== 2'b00) $display("FAIL rmid_full: got %b expected 00", bank_full_a); else n_pass++;
        sys_rst = 1'b0;
        settle();
        n_checks++; if (wr_adr_a.size() - wb !== 0) $display("FAIL rmid_nowrite: got %0d expected 0", wr_adr_a.size() - wb); else n_pass++;
        for (int i = 0; i < 16; i++) strobe(2'b10, 8'h00, 1'b0, 2'b00);
        settle();
        ga = (wr_adr_a.size() > wb) ? wr_adr_a[wb] : 3'bxxx;
        gd = (wr_dat_a.size() > wb) ? wr_dat_a[wb] : 32'hxxxxxxxx;
        n_checks++; if (ga !== 3'd0) $display("FAIL rmid_adr: got %h expected 0", ga); else n_pass++;
        n_checks++; if (gd !== 32'hAAAAAAAA) $display("FAIL rmid_dat: got %h expected aaaaaaaa", gd); else n_pass++;
    endtask

    task automatic test_wide();
        int wb;
        logic [7:0] vec [8];
        logic [9:0]  ga;
        logic [31:0] gd;
        vec = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF0, 8'h0F, 8'hAA, 8'h55};
        set_en(1'b0, 1'b0);
        set_en(1'b1, 1'b0);
        wb = wr_adr_b.size();
        for (int i = 0; i < 8; i++) strobe(2'b00, vec[i], 1'b0, 2'b00);
        settle();
        n_checks++; if (wr_adr_b.size() - wb !== 2) $display("FAIL wide_count: got %0d expected 2", wr_adr_b.size() - wb); else n_pass++;
        ga = (wr_adr_b.size() > wb) ? wr_adr_b[wb] : 10'bx;
        gd = (wr_dat_b.size() > wb) ? wr_dat_b[wb] : 32'hxxxxxxxx;
        n_checks++; if (ga !== 10'd0) $display("FAIL wide_adr0: got %h expected 0", ga); else n_pass++;
        n_checks++; if (gd !== 32'h04030201) $display("FAIL wide_dat0: got %h expected 04030201", gd); else n_pass++;
        ga = (wr_adr_b.size() > wb + 1) ? wr_adr_b[wb + 1] : 10'bx;
        gd = (wr_dat_b.size() > wb + 1) ? wr_dat_b[wb + 1] : 32'hxxxxxxxx;
        n_checks++; if (ga !== 10'd1) $display("FAIL wide_adr1: got %h expected 1", ga); else n_pass++;
        n_checks++; if (gd !== 32'h55AA0FF0) $display("FAIL wide_dat1: got %h expected 55aa0ff0", gd); else n_pass++;
    endtask

    // Test sequence
    initial begin
        sys_rst = 1'b1; gps_clk = 1'b0; gps_sync = 1'b0;
        gps_data_a = 2'b00; gps_data_b = 8'h00;
        enable = 1'b0; sync_align = 1'b0; bank_ack = 2'b00;
        test_reset();
        test_basic();
        test_sync_align();
        test_fill_overflow();
        test_disable_reenable();
        test_ack_collision();
        test_reset_mid();
        test_wide();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
